// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: N-phase traffic-light controller with programmable
// per-phase green time, fixed yellow/all-red clearance and a latched pedestrian
// WALK interval. All intervals count tick_i strobes, not clk cycles.
// Optional flash mode is compiled in with `define TPS_FLASH_EN.
module traffic_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int PED_T      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_i,
    input  logic [NUM_PHASES*CNT_W-1:0]   green_time_i,
    input  logic                          ped_req_i,
    input  logic                          flash_i,
    output logic [3*NUM_PHASES-1:0]       light_o,
    output logic                          ped_walk_o,
    output logic                          ped_wait_o,
    output logic [$clog2(NUM_PHASES)-1:0] phase_o,
    output logic [2:0]                    state_o
);

    localparam int PH_W = $clog2(NUM_PHASES);
    localparam logic [PH_W-1:0]  LAST_PH    = PH_W'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LD     = CNT_W'(PED_T - 1);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_FLASH  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ped_wait_q, ped_wait_d;
    logic [CNT_W-1:0]   green_sel;
    logic [CNT_W-1:0]   green_ld;

`ifdef TPS_FLASH_EN
    // Flash blink phase: 0 shows yellow, 1 shows dark.
    logic               tog_q, tog_d;
`else
    logic               unused_flash;
    assign unused_flash = flash_i;
`endif

    // Green reload for the current phase; a programmed 0 still gives one tick.
    always_comb begin
        green_sel = green_time_i[phase_q*CNT_W +: CNT_W];
        green_ld  = (green_sel == '0) ? '0 : green_sel - CNT_W'(1);
    end

    // State, phase, interval counter and pedestrian latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_ALLRED;
            phase_q    <= '0;
            cnt_q      <= ALLRED_LD;
            ped_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            ped_wait_q <= ped_wait_d;
        end
    end

`ifdef TPS_FLASH_EN
    // Flash blink register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tog_q <= 1'b0;
        else     tog_q <= tog_d;
    end
`endif

    // Next-state: counters run on tick only; a tick at cnt==0 ends the interval.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        ped_wait_d = ped_wait_q | ped_req_i;
        if (tick_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                case (state_q)
                    S_ALLRED: begin
                        if (ped_wait_q) begin
                            state_d    = S_WALK;
                            cnt_d      = PED_LD;
                            // A request on this very edge keeps the latch armed.
                            ped_wait_d = ped_req_i;
                        end else begin
                            state_d = S_GREEN;
                            cnt_d   = green_ld;
                        end
                    end
                    S_WALK: begin
                        state_d = S_GREEN;
                        cnt_d   = green_ld;
                    end
                    S_GREEN: begin
                        state_d = S_YELLOW;
                        cnt_d   = YELLOW_LD;
                    end
                    S_YELLOW: begin
                        state_d = S_ALLRED;
                        cnt_d   = ALLRED_LD;
                        phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
`ifdef TPS_FLASH_EN
        tog_d = tog_q;
        if (state_q == S_FLASH && tick_i) tog_d = ~tog_q;
        if (flash_i) begin
            state_d = S_FLASH;
            if (state_q != S_FLASH) tog_d = 1'b0;
        end else if (state_q == S_FLASH) begin
            state_d = S_ALLRED;
            phase_d = '0;
            cnt_d   = ALLRED_LD;
        end
`endif
    end

    // Lamp decode: only the owning group may leave red, and only in GREEN/YELLOW.
    always_comb begin
        for (int p = 0; p < NUM_PHASES; p++) begin
            light_o[3*p +: 3] = 3'b100;
            if (phase_q == PH_W'(p)) begin
                if (state_q == S_GREEN)  light_o[3*p +: 3] = 3'b001;
                if (state_q == S_YELLOW) light_o[3*p +: 3] = 3'b010;
            end
`ifdef TPS_FLASH_EN
            if (state_q == S_FLASH) light_o[3*p +: 3] = tog_q ? 3'b000 : 3'b010;
`endif
        end
    end

    assign ped_walk_o = (state_q == S_WALK);
    assign ped_wait_o = ped_wait_q;
    assign phase_o    = phase_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: expected per-cycle outputs are
// queued as each stimulus segment is applied and checked one per clock.
module tb_traffic_phase_sequencer;

    localparam logic [2:0] A = 3'd0, G = 3'd1, Y = 3'd2, W = 3'd3, F = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [31:0] green_time;
    logic        ped_req;
    logic        flash;
    logic [11:0] light;
    logic        ped_walk;
    logic        ped_wait;
    logic [1:0]  phase;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  st;
        logic [1:0]  ph;
        logic        walk;
        logic        wt;
        logic [11:0] light;
        logic        chk_ph;
    } exp_t;

    exp_t sb[$];

    traffic_phase_sequencer #(
        .NUM_PHASES(4), .CNT_W(8), .YELLOW_T(2), .ALLRED_T(1), .PED_T(6)
    ) dut (
        .clk(clk), .rst(rst), .tick_i(tick), .green_time_i(green_time),
        .ped_req_i(ped_req), .flash_i(flash), .light_o(light),
        .ped_walk_o(ped_walk), .ped_wait_o(ped_wait), .phase_o(phase),
        .state_o(state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lamps(input logic [2:0] st, input int ph);
        logic [11:0] l;
        l = 12'b100100100100;
        if (st == G) l[3*ph +: 3] = 3'b001;
        if (st == Y) l[3*ph +: 3] = 3'b010;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pop and compare one expected entry per clock, sampled at negedge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", 32'(state), 32'(e.st));
            if (e.chk_ph) chk("phase", 32'(phase), 32'(e.ph));
            chk("light", 32'(light), 32'(e.light));
            chk("ped_walk", 32'(ped_walk), 32'(e.walk));
            chk("ped_wait", 32'(ped_wait), 32'(e.wt));
            @(negedge clk);
        end
    endtask

    task automatic seg(input logic [2:0] st, input int ph, input logic wk,
                       input logic wt, input int n);
        exp_t e;
        e.st = st; e.ph = 2'(ph); e.walk = wk; e.wt = wt;
        e.light = lamps(st, ph); e.chk_ph = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(e);
        drain();
    endtask

`ifdef TPS_FLASH_EN
    task automatic flash_seg(input logic dark, input logic wt);
        exp_t e;
        e.st = F; e.ph = 2'd0; e.walk = 1'b0; e.wt = wt;
        e.light = dark ? 12'b000000000000 : 12'b010010010010; e.chk_ph = 1'b0;
        sb.push_back(e);
        drain();
    endtask
`endif

    initial begin
        rst = 1'b1; tick = 1'b1; ped_req = 1'b0; flash = 1'b0;
        green_time = {8'd5, 8'd3, 8'd2, 8'd4};
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'(A));
        chk("rst_light", 32'(light), 32'h924);
        chk("rst_wait", 32'(ped_wait), 32'd0);
        rst = 1'b0;

        // Full rotation, no pedestrian, phase wraps 3 -> 0.
        seg(A,0,0,0,1); seg(G,0,0,0,4); seg(Y,0,0,0,2);
        seg(A,1,0,0,1); seg(G,1,0,0,2); seg(Y,1,0,0,2);
        seg(A,2,0,0,1); seg(G,2,0,0,3); seg(Y,2,0,0,2);
        seg(A,3,0,0,1); seg(G,3,0,0,5); seg(Y,3,0,0,2);
        seg(A,0,0,0,1);

        // Tick stall mid-GREEN, and green_time 0 for p1 gives one tick.
        green_time[15:8] = 8'd0;
        seg(G,0,0,0,1); tick = 1'b0; seg(G,0,0,0,10); tick = 1'b1;
        seg(G,0,0,0,3); seg(Y,0,0,0,2);
        seg(A,1,0,0,1); seg(G,1,0,0,1); seg(Y,1,0,0,2);
        seg(A,2,0,0,1); seg(G,2,0,0,3); seg(Y,2,0,0,2);
        seg(A,3,0,0,1); seg(G,3,0,0,5); seg(Y,3,0,0,2);
        seg(A,0,0,0,1);

        // Pedestrian pulse during p0 GREEN -> WALK before p1 GREEN.
        ped_req = 1'b1; seg(G,0,0,0,1); ped_req = 1'b0;
        seg(G,0,0,1,3); seg(Y,0,0,1,2); seg(A,1,0,1,1);
        seg(W,1,1,0,6); seg(G,1,0,0,1); seg(Y,1,0,0,2); seg(A,2,0,0,1);

        // Request held on the ALLRED->WALK edge keeps ped_wait set.
        ped_req = 1'b1; seg(G,2,0,0,1); ped_req = 1'b0;
        seg(G,2,0,1,2); seg(Y,2,0,1,2);
        ped_req = 1'b1; seg(A,3,0,1,1); ped_req = 1'b0;
        seg(W,3,1,1,6); seg(G,3,0,1,5); seg(Y,3,0,1,2);
        seg(A,0,0,1,1); seg(W,0,1,0,6); seg(G,0,0,0,4);
        seg(Y,0,0,0,2); seg(A,1,0,0,1); seg(G,1,0,0,1); seg(Y,1,0,0,2);
        seg(A,2,0,0,1); seg(G,2,0,0,3);

        // Flash request in p2 YELLOW.
        flash = 1'b1;
`ifdef TPS_FLASH_EN
        seg(Y,2,0,0,1);
        flash_seg(1'b0,1'b0); flash_seg(1'b1,1'b0); flash_seg(1'b0,1'b0);
        flash = 1'b0;
        flash_seg(1'b1,1'b0);
        seg(A,0,0,0,1); seg(G,0,0,0,2);
`else
        seg(Y,2,0,0,2); seg(A,3,0,0,1);
        flash = 1'b0;
        seg(G,3,0,0,2);
`endif

        // Asynchronous reset asserted mid-GREEN.
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'(A));
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_light", 32'(light), 32'h924);
        chk("arst_walk", 32'(ped_walk), 32'd0);
        chk("arst_wait", 32'(ped_wait), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seg(A,0,0,0,1); seg(G,0,0,0,1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
